// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
// Shared widths and FSM state encoding for the instruction fetch front end.
//   ADDR_W  : default PC / memory address width
//   WORD_W  : default instruction width
//   state_e : sequencer states (IDLE=0, FETCH=1, HALT=2)
package fetch_sequencer_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer
// One-entry {pc, inst} holding register. Catches the fetched word that is
// already in flight when the downstream queue stalls.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   i_capture           : load i_pc/i_inst and mark the entry valid
//   i_clear             : held word accepted downstream, drop it
//   i_flush             : branch redirect, discard the entry (highest priority)
//   i_pc, i_inst        : word being captured
//   o_valid, o_pc, o_inst : held entry
module fetch_skid_buffer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR = ADDR_W,
    parameter int unsigned WORD = WORD_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_capture,
    input  logic            i_clear,
    input  logic            i_flush,
    input  logic [ADDR-1:0] i_pc,
    input  logic [WORD-1:0] i_inst,
    output logic            o_valid,
    output logic [ADDR-1:0] o_pc,
    output logic [WORD-1:0] o_inst
);

    logic            r_valid;
    logic [ADDR-1:0] r_pc;
    logic [WORD-1:0] r_inst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Front-end controller: owns the PC, drives the synchronous instruction
// memory, feeds the fetch queue, honours its stall and redirects on branches.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   start_i, halt_i         : leave IDLE / stop issuing new fetches
//   branch_i, branch_pc_i   : taken-branch redirect and target
//   stall_i                 : queue cannot accept this cycle
//   imem_req_o, imem_addr_o : memory read strobe and address
//   imem_data_i             : read data, valid the cycle after the request
//   v_o, inst_o, pc_o       : instruction to the queue
//   flush_o                 : queue flush (follows branch_i)
//   fetch_cnt_o             : number of issued requests, wrapping
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     ADDR     = ADDR_W,
    parameter int unsigned     WORD     = WORD_W,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_pc_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [ADDR-1:0] imem_addr_o,
    input  logic [WORD-1:0] imem_data_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    output logic            flush_o,
    output logic [31:0]     fetch_cnt_o
);

    state_e          r_state;
    logic [ADDR-1:0] r_pc;
    logic            r_infl_v;
    logic [ADDR-1:0] r_infl_pc;
    logic [31:0]     r_fetch_cnt;

    logic            w_issue;
    logic            w_capture;
    logic            w_skid_v;
    logic [ADDR-1:0] w_skid_pc;
    logic [WORD-1:0] w_skid_inst;

    assign w_issue = (r_state == FETCH) & ~stall_i & ~branch_i;
    // Capture cycles never issue, so skid and in-flight are never both valid.
    assign w_capture = stall_i & r_infl_v & ~w_skid_v & ~branch_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_infl_v    <= 1'b0;
            r_infl_pc   <= '0;
            r_fetch_cnt <= '0;
        end else begin
            r_infl_v <= w_issue;
            if (w_issue) begin
                r_infl_pc   <= r_pc;
                r_pc        <= r_pc + ADDR'(PC_STEP);
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (branch_i) begin
                r_pc <= branch_pc_i;
            end
            // Branch outranks start/halt in every state.
            unique case (r_state)
                IDLE:    if (start_i && !branch_i) r_state <= FETCH;
                FETCH:   if (halt_i && !branch_i)  r_state <= HALT;
                HALT:    if (branch_i)             r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_skid_buffer #(
        .ADDR (ADDR),
        .WORD (WORD)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_capture),
        .i_clear   (~stall_i),
        .i_flush   (branch_i),
        .i_pc      (r_infl_pc),
        .i_inst    (imem_data_i),
        .o_valid   (w_skid_v),
        .o_pc      (w_skid_pc),
        .o_inst    (w_skid_inst)
    );

    always_comb begin
        v_o    = 1'b0;
        inst_o = '0;
        pc_o   = '0;
        if (w_skid_v) begin
            v_o    = 1'b1;
            inst_o = w_skid_inst;
            pc_o   = w_skid_pc;
        end else if (r_infl_v) begin
            v_o    = 1'b1;
            inst_o = imem_data_i;
            pc_o   = r_infl_pc;
        end
        if (branch_i) begin
            v_o = 1'b0;
        end
    end

    assign imem_req_o  = w_issue;
    assign imem_addr_o = r_pc;
    assign flush_o     = branch_i;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule
